// File: rtl/multi_adder_acc_pkg.sv
// Shared sizing and saturating-add helpers for the multi-operand adder.
// Helpers operate on a fixed wide word; callers slice out their own width.
package multi_adder_acc_pkg;

    localparam int MAXW = 64;

    typedef struct packed {
        logic [MAXW-1:0] val;
        logic            ovf;
    } sat_res_t;

    function automatic int calc_sw(input int w, input int n);
        return w + $clog2(n) + 1;
    endfunction

    // Adds in ow+1 bits; on overflow clamps to 2^ow-1 or wraps mod 2^ow.
    function automatic sat_res_t sat_add(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input int              ow,
        input bit              sat
    );
        sat_res_t        res;
        logic [MAXW:0]   r;
        logic [MAXW:0]   lim;
        r       = {1'b0, a} + {1'b0, b};
        lim     = (MAXW+1)'(1) << ow;
        res.ovf = (r >= lim);
        if (res.ovf) begin
            res.val = sat ? MAXW'(lim - 1'b1) : MAXW'(r - lim);
        end else begin
            res.val = MAXW'(r);
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_adder_acc_adder_tree.sv
// Combinational N-operand plus carry-in adder, result in SW bits.
// Width is chosen so the sum can never overflow.
module adder_tree
    import multi_adder_acc_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = calc_sw(W, N)
) (
    input  logic [N*W-1:0] ins,
    input  logic           cin,
    output logic [SW-1:0]  bsum
);

    always_comb begin
        bsum = SW'(cin);
        for (int k = 0; k < N; k++) begin
            bsum = bsum + SW'(ins[k*W +: W]);
        end
    end

endmodule

// File: rtl/multi_adder_acc.sv
// Two-stage pipelined N-operand adder with running accumulate,
// wrap/saturate overflow handling and valid/ready flow control.
module multi_adder_acc
    import multi_adder_acc_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int OW  = 16,
    parameter int SAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] ins,
    input  logic           cin,
    input  logic           acc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  sum,
    output logic           sum_zero,
    output logic           ovf
);

    localparam int SW = calc_sw(W, N);

    logic [SW-1:0] bsum;
    logic [SW-1:0] s1_bsum;
    logic          s1_acc;
    logic          s1_valid;
    logic [OW-1:0] acc_reg;
    logic          s2_adv;
    logic [OW-1:0] base;
    logic [OW-1:0] new_sum;
    sat_res_t      res;
    logic          unused_hi;

    adder_tree #(
        .W  (W),
        .N  (N),
        .SW (SW)
    ) u_tree (
        .ins  (ins),
        .cin  (cin),
        .bsum (bsum)
    );

    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;

    always_comb begin
        base      = s1_acc ? acc_reg : '0;
        res       = sat_add(MAXW'(base), MAXW'(s1_bsum), OW, SAT != 0);
        new_sum   = res.val[OW-1:0];
        unused_hi = ^res.val[MAXW-1:OW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_bsum  <= '0;
            s1_acc   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_bsum <= bsum;
                s1_acc  <= acc;
            end
        end
    end

    // acc_reg tracks S2 loads only; an output handshake leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            sum_zero  <= 1'b0;
            ovf       <= 1'b0;
            acc_reg   <= '0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            sum       <= new_sum;
            sum_zero  <= (new_sum == '0);
            ovf       <= res.ovf;
            acc_reg   <= new_sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_adder_acc.sv
// Scoreboard bench: a saturating and a wrapping instance share one stream.
// Expected results are queued at acceptance and checked at output handshake.
module tb_multi_adder_acc;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int OW = 16;

    typedef struct {
        int s;
        bit z;
        bit o;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           out_ready;
    logic           cin;
    logic           acc;
    logic [N*W-1:0] ins;

    logic           in_ready_s, out_valid_s, sum_zero_s, ovf_s;
    logic           in_ready_w, out_valid_w, sum_zero_w, ovf_w;
    logic [OW-1:0]  sum_s, sum_w;

    exp_t q_s[$];
    exp_t q_w[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_s  = 0;
    int   acc_w  = 0;

    always #5 clk = ~clk;

    multi_adder_acc #(.W(W), .N(N), .OW(OW), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ins(ins), .cin(cin), .acc(acc), .out_valid(out_valid_s),
        .out_ready(out_ready), .sum(sum_s), .sum_zero(sum_zero_s), .ovf(ovf_s)
    );

    multi_adder_acc #(.W(W), .N(N), .OW(OW), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .ins(ins), .cin(cin), .acc(acc), .out_valid(out_valid_w),
        .out_ready(out_ready), .sum(sum_w), .sum_zero(sum_zero_w), .ovf(ovf_w)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(inout int a, input logic [31:0] v,
                                   input bit c, input bit ac, input bit sat);
        exp_t e;
        int   r;
        r = int'(c);
        for (int k = 0; k < N; k++) r += int'(v[k*8 +: 8]);
        if (ac) r += a;
        e.o = (r >= 65536);
        if (e.o) r = sat ? 65535 : r - 65536;
        a   = r;
        e.s = r;
        e.z = (r == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (out_valid_s) begin
                if (q_s.size() == 0) begin
                    chk("sat_unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = q_s.pop_front();
                    chk("sat_sum", 32'(sum_s), e.s);
                    chk("sat_zero", 32'(sum_zero_s), 32'(e.z));
                    chk("sat_ovf", 32'(ovf_s), 32'(e.o));
                end
            end
            if (out_valid_w) begin
                if (q_w.size() == 0) begin
                    chk("wrap_unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = q_w.pop_front();
                    chk("wrap_sum", 32'(sum_w), e.s);
                    chk("wrap_zero", 32'(sum_zero_w), 32'(e.z));
                    chk("wrap_ovf", 32'(ovf_w), 32'(e.o));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [31:0] v, input bit c, input bit ac);
        bit hs;
        in_valid = 1'b1;
        ins      = v;
        cin      = c;
        acc      = ac;
        hs       = 1'b0;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = in_ready_s;
            @(posedge clk);
        end
        if (!hs) chk("accept_timeout", 0, 1);
        q_s.push_back(model(acc_s, v, c, ac, 1'b1));
        q_w.push_back(model(acc_w, v, c, ac, 1'b0));
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while ((q_s.size() != 0 || q_w.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ins       = '0;
        cin       = 1'b0;
        acc       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_s", 32'(out_valid_s), 0);
        chk("rst_sum_s", 32'(sum_s), 0);
        chk("rst_zero_s", 32'(sum_zero_s), 0);
        chk("rst_ovf_s", 32'(ovf_s), 0);
        chk("rst_valid_w", 32'(out_valid_w), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready_s", 32'(in_ready_s), 1);
        chk("rst_in_ready_w", 32'(in_ready_w), 1);

        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        chk("lat_cycle1", 32'(out_valid_s), 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", 32'(out_valid_s), 1);
        drain();
        chk("single_sum", 32'(sum_s), 1021);
        chk("single_ovf", 32'(ovf_s), 0);

        send(32'h0, 1'b0, 1'b0);
        drain();
        chk("zero_flag", 32'(sum_zero_s), 1);
        chk("zero_sum", 32'(sum_s), 0);

        out_ready = 1'b0;
        fork
            begin
                send(32'd10, 1'b0, 1'b0);
                send(32'd20, 1'b0, 1'b0);
                send(32'd30, 1'b0, 1'b0);
                send(32'd40, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("bp_in_ready", 32'(in_ready_s), 0);
                chk("bp_valid", 32'(out_valid_s), 1);
                chk("bp_hold", 32'(sum_s), 10);
                out_ready = 1'b1;
            end
        join
        drain();

        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) send(32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();
        chk("acc63_sat", 32'(sum_s), 65280);
        chk("acc63_ovf", 32'(ovf_s), 0);
        chk("acc63_wrap", 32'(sum_w), 65280);
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();
        chk("acc64_sat", 32'(sum_s), 65535);
        chk("acc64_sat_ovf", 32'(ovf_s), 1);
        chk("acc64_wrap", 32'(sum_w), 764);
        chk("acc64_wrap_ovf", 32'(ovf_w), 1);
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();
        chk("acc65_sat", 32'(sum_s), 65535);
        chk("acc65_sat_ovf", 32'(ovf_s), 1);
        chk("acc65_wrap", 32'(sum_w), 1784);
        chk("acc65_wrap_ovf", 32'(ovf_w), 0);
        send(32'd5, 1'b0, 1'b0);
        drain();
        chk("restart_sat", 32'(sum_s), 5);
        chk("restart_ovf", 32'(ovf_s), 0);
        chk("restart_wrap", 32'(sum_w), 5);

        out_ready = 1'b0;
        send(32'd7, 1'b0, 1'b1);
        send(32'd9, 1'b0, 1'b1);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("flush_valid_s", 32'(out_valid_s), 0);
        chk("flush_valid_w", 32'(out_valid_w), 0);
        chk("flush_sum_s", 32'(sum_s), 0);
        q_s.delete();
        q_w.delete();
        acc_s = 0;
        acc_w = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_stale", 32'(out_valid_s), 0);
        send(32'd5, 1'b0, 1'b1);
        drain();
        chk("flush_acc_s", 32'(sum_s), 5);
        chk("flush_acc_w", 32'(sum_w), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
